// File: rtl/key_debouncer_if.sv
// Button-side signal bundle: raw pin in, conditioned level and event pulses out.
interface key_debouncer_if;
  logic key;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  modport master (
    output key,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  long_press
  );

  modport slave (
    input  key,
    output key_level,
    output press_pulse,
    output release_pulse,
    output long_press
  );
endinterface

// File: rtl/key_debouncer.sv
// Synchronises and debounces one push-button; emits a clean level plus
// single-cycle press, release and long-press pulses.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500_000,
  parameter int unsigned LONG_PRESS_CYCLES = 25_000_000,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  key_debouncer_if.slave  bus
);

  localparam int unsigned CNT_W = ($clog2(LONG_PRESS_CYCLES) < 1) ? 1 : $clog2(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    DB_RELEASE
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] dbCnt_q, dbCnt_d;
  logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
  logic             longDone_q, longDone_d;
  logic             longDoneDly_q;
  logic             keyLevel_q, keyLevel_d;
  logic             pressPulse_q, pressPulse_d;
  logic             releasePulse_q, releasePulse_d;
  logic             longPress_q, longPress_d;
  logic             pressed;
  logic             holding;

  assign pressed = sync2_q ^ ACTIVE_LOW;
  assign holding = (state_q == PRESSED) || (state_q == DB_RELEASE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q        <= ACTIVE_LOW;
      sync2_q        <= ACTIVE_LOW;
      state_q        <= IDLE;
      dbCnt_q        <= '0;
      holdCnt_q      <= '0;
      longDone_q     <= 1'b0;
      longDoneDly_q  <= 1'b0;
      keyLevel_q     <= 1'b0;
      pressPulse_q   <= 1'b0;
      releasePulse_q <= 1'b0;
      longPress_q    <= 1'b0;
    end else begin
      sync1_q        <= bus.key;
      sync2_q        <= sync1_q;
      state_q        <= state_d;
      dbCnt_q        <= dbCnt_d;
      holdCnt_q      <= holdCnt_d;
      longDone_q     <= longDone_d;
      longDoneDly_q  <= longDone_q;
      keyLevel_q     <= keyLevel_d;
      pressPulse_q   <= pressPulse_d;
      releasePulse_q <= releasePulse_d;
      longPress_q    <= longPress_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dbCnt_d   = dbCnt_q;
    holdCnt_d = holdCnt_q;
    unique case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = DB_PRESS;
          dbCnt_d = '0;
        end
      end
      DB_PRESS: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (dbCnt_q == DB_LAST) begin
          state_d = PRESSED;
        end else begin
          dbCnt_d = dbCnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d = DB_RELEASE;
          dbCnt_d = '0;
        end
      end
      DB_RELEASE: begin
        if (pressed) begin
          state_d = PRESSED;
        end else if (dbCnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          dbCnt_d = dbCnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (holding && (holdCnt_q != HOLD_LAST)) begin
      holdCnt_d = holdCnt_q + CNT_W'(1);
    end
    if ((state_q == DB_PRESS) && (state_d == PRESSED)) begin
      holdCnt_d = '0;
    end

    // The hold counter idles at its saturated value, so only trust it while held.
    longDone_d = longDone_q;
    if (holding && (holdCnt_q == HOLD_LAST)) begin
      longDone_d = 1'b1;
    end
    if ((state_d == IDLE) && (state_q != IDLE)) begin
      longDone_d = 1'b0;
    end

    keyLevel_d     = (state_d == PRESSED) || (state_d == DB_RELEASE);
    pressPulse_d   = (state_q == DB_PRESS) && (state_d == PRESSED);
    releasePulse_d = (state_q == DB_RELEASE) && (state_d == IDLE);
    longPress_d    = longDone_q && !longDoneDly_q;
  end

  assign bus.key_level     = keyLevel_q;
  assign bus.press_pulse   = pressPulse_q;
  assign bus.release_pulse = releasePulse_q;
  assign bus.long_press    = longPress_q;

endmodule
